text_console: RTL and testbench
===============================

// Module: text_console
// PURPOSE
//   Upstream feeder for the gpu text RAM write port. Takes a byte stream of ASCII characters
//   (valid/ready) and keeps a hardware cursor. Printable bytes become writes into the 80x30
//   character RAM. Control codes are interpreted: CR, LF, BS and FF (clear screen).
//   The CPU only pushes characters; it does not compute RAM addresses.
// PARAMETERS
//   COLS        80     characters per row
//   ROWS        30     rows per screen
//   BLANK_CHAR  8'h20  fill code written by clear and by backspace
// PORTS
//   clk         in   1   system clock (same clock as the gpu write port)
//   rst_n       in   1   asynchronous, active-low reset
//   char_in     in   8   incoming byte
//   char_valid  in   1   char_in is valid
//   char_ready  out  1   block can accept a byte this cycle
//   vram_addr   out  12  text RAM write address = row*COLS + col
//   vram_data   out  8   text RAM write data
//   vram_w_en   out  1   one-cycle write strobe (to gpu v_w_en)
//   cursor_col  out  7   current column, 0..COLS-1
//   cursor_row  out  5   current row, 0..ROWS-1
//   busy        out  1   high while a clear is in progress
// BEHAVIOUR
//   Reset: all outputs are 0, except char_ready=1. Cursor is at (0,0) and the FSM is in IDLE.
//   A byte is accepted on any edge where char_valid && char_ready. The resulting
//   vram_addr/data/w_en are registered, so the write appears exactly 1 cycle after acceptance.
//   vram_w_en is high for one cycle only. The cursor update becomes visible on the same
//   cycle as the write.
//   FSM states: IDLE and CLEAR.
//   IDLE: char_ready=1. Decoding of an accepted byte b:
//     0x20..0x7E (printable): write b at (row,col), then advance the cursor.
//       col<COLS-1: col+1.
//       Otherwise: col=0 and row+1; row wraps from ROWS-1 to 0. There is no scrolling.
//     0x0D (CR): col=0. No write.
//     0x0A (LF): col=0 and row+1, with the same wrap as above. No write.
//     0x08 (BS): move the cursor back one cell, then write BLANK_CHAR at the new position.
//       At col 0 with row>0, the cursor goes to (row-1, COLS-1).
//       At (0,0) BS is a no-op and produces no write.
//     0x0C (FF): go to CLEAR. char_ready drops on the next cycle.
//     Any other byte (0x00..0x1F other than those above, and 0x7F..0xFF): ignored.
//       The byte is still consumed. No write, and the cursor does not change.
//   CLEAR: char_ready=0 and busy=1. One write of BLANK_CHAR per cycle to addresses
//     0..COLS*ROWS-1 (0..2399), in increasing order, with no gaps.
//     After the write to address 2399, the FSM returns to IDLE. On that return the cursor
//     is set to (0,0), busy=0 and char_ready=1.
//     A clear takes exactly COLS*ROWS write cycles.
//   Writes always stay below COLS*ROWS. vram_addr is never >= 2400.
//   Address arithmetic: row*COLS+col is computed 12 bits wide. A constant-multiply
//     implementation is acceptable; an incrementally tracked linear address is also fine,
//     as long as it is equal on every cycle.
//   char_valid is ignored while char_ready=0. The upstream producer holds the byte until
//     it is accepted.
//   If rst_n is asserted in the middle of a clear, the clear is aborted at once and all
//     state returns to reset values. Cells not yet cleared keep their old contents.
// STRUCTURE
//   Single module with no sub-modules: one 2-state FSM, cursor row/col registers,
//     a 12-bit clear counter, and the output registers.
//   Shared header console_defs.vh holds:
//     control codes CH_CR=8'h0D, CH_LF=8'h0A, CH_BS=8'h08, CH_FF=8'h0C;
//     the printable range bounds 8'h20 and 8'h7E;
//     the state encodings ST_IDLE and ST_CLEAR.
//   The COLS and ROWS defaults must match the gpu text RAM geometry (2400 cells).
// TESTING
//   1. After reset, send 'A' (0x41) -> next cycle: vram_w_en=1, addr=0, data=0x41;
//      cursor (col=1,row=0).
//   2. Set cursor to (79,5) by sending 479 printable bytes, then send 'Z'
//      -> write at addr 479, cursor becomes (0,6).
//      Then send LF at row 29 -> cursor (0,0) with no write.
//   3. From (0,3), send BS -> write 0x20 at addr 239, cursor (79,2).
//      From (0,0), send BS -> no write, cursor unchanged.
//   4. Send FF -> busy=1 and char_ready=0 for exactly 2400 cycles.
//      The writes cover addresses 0..2399 consecutively, all with data 0x20.
//      The FSM then returns to IDLE with the cursor at (0,0).
//   5. Assert rst_n low 100 cycles into a clear -> writes stop immediately.
//      After release: char_ready=1, busy=0, cursor (0,0).
//   6. Send 0x07 and 0xFF, each with char_valid held for 1 cycle -> both are consumed,
//      no vram_w_en, cursor unchanged.

Source files
------------

// File: rtl/text_console_pkg.sv
// Shared constants for the text console: control codes, printable range and FSM states.
package text_console_pkg;

  localparam logic [7:0] CH_CR       = 8'h0D;
  localparam logic [7:0] CH_LF       = 8'h0A;
  localparam logic [7:0] CH_BS       = 8'h08;
  localparam logic [7:0] CH_FF       = 8'h0C;
  localparam logic [7:0] CH_PRINT_LO = 8'h20;
  localparam logic [7:0] CH_PRINT_HI = 8'h7E;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } state_t;

  function automatic logic is_printable(input logic [7:0] b);
    return (b >= CH_PRINT_LO) && (b <= CH_PRINT_HI);
  endfunction

endpackage

// File: rtl/text_console.sv
// Byte-stream front end for the gpu text RAM: keeps a hardware cursor, turns printable
// bytes into RAM writes, interprets CR/LF/BS and clears the screen on FF.
module text_console
  import text_console_pkg::*;
#(
  parameter int         COLS       = 80,
  parameter int         ROWS       = 30,
  parameter logic [7:0] BLANK_CHAR = 8'h20
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  char_in,
  input  logic        char_valid,
  output logic        char_ready,
  output logic [11:0] vram_addr,
  output logic [7:0]  vram_data,
  output logic        vram_w_en,
  output logic [6:0]  cursor_col,
  output logic [4:0]  cursor_row,
  output logic        busy
);

  localparam logic [6:0]  COL_LAST = 7'(COLS - 1);
  localparam logic [4:0]  ROW_LAST = 5'(ROWS - 1);
  localparam logic [11:0] COLS_W   = 12'(COLS);
  localparam logic [11:0] CELLS    = 12'(COLS * ROWS);

  state_t      state;
  logic [11:0] clr_addr;
  logic        accept;
  logic [4:0]  row_next;

  function automatic logic [11:0] cell_addr(input logic [4:0] row, input logic [6:0] col);
    return {7'd0, row} * COLS_W + {5'd0, col};
  endfunction

  assign accept   = char_valid && char_ready;
  assign row_next = (cursor_row == ROW_LAST) ? 5'd0 : cursor_row + 5'd1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      char_ready <= 1'b1;
      busy       <= 1'b0;
      vram_w_en  <= 1'b0;
      vram_addr  <= '0;
      vram_data  <= '0;
      cursor_col <= '0;
      cursor_row <= '0;
      clr_addr   <= '0;
    end else begin
      vram_w_en <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            if (is_printable(char_in)) begin
              vram_addr <= cell_addr(cursor_row, cursor_col);
              vram_data <= char_in;
              vram_w_en <= 1'b1;
              if (cursor_col != COL_LAST) begin
                cursor_col <= cursor_col + 7'd1;
              end else begin
                cursor_col <= '0;
                cursor_row <= row_next;
              end
            end else begin
              case (char_in)
                CH_CR: cursor_col <= '0;
                CH_LF: begin
                  cursor_col <= '0;
                  cursor_row <= row_next;
                end
                CH_BS: begin
                  // Backspace at the home position has nowhere to go and writes nothing.
                  if (cursor_col != 7'd0) begin
                    cursor_col <= cursor_col - 7'd1;
                    vram_addr  <= cell_addr(cursor_row, cursor_col - 7'd1);
                    vram_data  <= BLANK_CHAR;
                    vram_w_en  <= 1'b1;
                  end else if (cursor_row != 5'd0) begin
                    cursor_col <= COL_LAST;
                    cursor_row <= cursor_row - 5'd1;
                    vram_addr  <= cell_addr(cursor_row - 5'd1, COL_LAST);
                    vram_data  <= BLANK_CHAR;
                    vram_w_en  <= 1'b1;
                  end
                end
                CH_FF: begin
                  // Cell 0 is written on the accepting edge so the sweep has no gap.
                  state      <= ST_CLEAR;
                  char_ready <= 1'b0;
                  busy       <= 1'b1;
                  vram_addr  <= '0;
                  vram_data  <= BLANK_CHAR;
                  vram_w_en  <= 1'b1;
                  clr_addr   <= 12'd1;
                end
                default: ;
              endcase
            end
          end
        end
        ST_CLEAR: begin
          if (clr_addr == CELLS) begin
            state      <= ST_IDLE;
            char_ready <= 1'b1;
            busy       <= 1'b0;
            cursor_col <= '0;
            cursor_row <= '0;
          end else begin
            vram_addr <= clr_addr;
            vram_data <= BLANK_CHAR;
            vram_w_en <= 1'b1;
            clr_addr  <= clr_addr + 12'd1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_text_console.sv
// Self-checking bench for text_console: linear-cursor reference model plus directed literal checks.
module tb_text_console;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [7:0]  char_in = 8'h00;
  logic        char_valid = 1'b0;
  logic        char_ready;
  logic [11:0] vram_addr;
  logic [7:0]  vram_data;
  logic        vram_w_en;
  logic [6:0]  cursor_col;
  logic [4:0]  cursor_row;
  logic        busy;

  int checks = 0;
  int passes = 0;
  int fail_prints = 0;
  bit cmp_en = 1'b0;

  text_console dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .char_in    (char_in),
    .char_valid (char_valid),
    .char_ready (char_ready),
    .vram_addr  (vram_addr),
    .vram_data  (vram_data),
    .vram_w_en  (vram_w_en),
    .cursor_col (cursor_col),
    .cursor_row (cursor_row),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  // Reference model: cursor is a single linear cell index, screen is 80x30.
  int         m_pos;
  int         m_next;
  bit         m_clearing;
  logic       m_we, m_ready, m_busy;
  logic [11:0] m_addr;
  logic [7:0]  m_data;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_pos = 0; m_next = 0; m_clearing = 0;
      m_we = 0; m_ready = 1; m_busy = 0; m_addr = 0; m_data = 0;
    end else begin
      m_we = 0;
      if (m_clearing) begin
        if (m_next < 2400) begin
          m_we = 1; m_addr = 12'(m_next); m_data = 8'h20; m_next++;
        end else begin
          m_clearing = 0; m_busy = 0; m_ready = 1; m_pos = 0;
        end
      end else if (char_valid && m_ready) begin
        if (char_in >= 8'h20 && char_in <= 8'h7E) begin
          m_we = 1; m_addr = 12'(m_pos); m_data = char_in;
          m_pos = (m_pos + 1) % 2400;
        end else if (char_in == 8'h0D) begin
          m_pos = (m_pos / 80) * 80;
        end else if (char_in == 8'h0A) begin
          m_pos = ((m_pos / 80 + 1) % 30) * 80;
        end else if (char_in == 8'h08) begin
          if (m_pos > 0) begin
            m_pos--; m_we = 1; m_addr = 12'(m_pos); m_data = 8'h20;
          end
        end else if (char_in == 8'h0C) begin
          m_clearing = 1; m_busy = 1; m_ready = 0;
          m_we = 1; m_addr = 12'd0; m_data = 8'h20; m_next = 1;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      logic [6:0] ec;
      logic [4:0] er;
      bit ok;
      ec = 7'(m_pos % 80);
      er = 5'(m_pos / 80);
      ok = (vram_w_en === m_we) && (char_ready === m_ready) && (busy === m_busy) &&
           (cursor_col === ec) && (cursor_row === er) &&
           (!m_we || (vram_addr === m_addr && vram_data === m_data));
      checks++;
      if (ok) passes++;
      else if (fail_prints < 20) begin
        fail_prints++;
        $display("FAIL model_cmp t=%0t got we=%0b addr=%0d data=%h rdy=%0b busy=%0b col=%0d row=%0d, want we=%0b addr=%0d data=%h rdy=%0b busy=%0b col=%0d row=%0d",
                 $time, vram_w_en, vram_addr, vram_data, char_ready, busy, cursor_col, cursor_row,
                 m_we, m_addr, m_data, m_ready, m_busy, ec, er);
      end
    end
  end

  task automatic check_lit(input string name, input logic we, input logic [11:0] addr,
                           input logic [7:0] data, input logic [6:0] col, input logic [4:0] row,
                           input logic rdy, input logic bsy, input bit chk_ad);
    bit ok;
    ok = (vram_w_en === we) && (cursor_col === col) && (cursor_row === row) &&
         (char_ready === rdy) && (busy === bsy) &&
         (!chk_ad || (vram_addr === addr && vram_data === data));
    checks++;
    if (ok) passes++;
    else $display("FAIL %s got we=%0b addr=%0d data=%h col=%0d row=%0d rdy=%0b busy=%0b, want we=%0b addr=%0d data=%h col=%0d row=%0d rdy=%0b busy=%0b",
                  name, vram_w_en, vram_addr, vram_data, cursor_col, cursor_row, char_ready, busy,
                  we, addr, data, col, row, rdy, bsy);
  endtask

  task automatic send(input logic [7:0] b);
    int n = 0;
    while (char_ready !== 1'b1 && n < 4000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 4000) begin
      checks++;
      $display("FAIL ready_timeout got char_ready=%0b, want 1", char_ready);
    end
    @(posedge clk); #1;
    char_in = b; char_valid = 1'b1;
    @(posedge clk); #1;
    char_valid = 1'b0;
  endtask

  initial begin
    int cnt;
    #1 rst_n = 1'b0;
    #1 cmp_en = 1'b1;
    repeat (3) @(negedge clk);
    check_lit("reset", 0, 12'd0, 8'h00, 7'd0, 5'd0, 1, 0, 1);
    @(posedge clk); #1 rst_n = 1'b1;

    // 1: first printable byte
    send(8'h41); @(negedge clk);
    check_lit("first_A", 1, 12'd0, 8'h41, 7'd1, 5'd0, 1, 0, 1);

    // 2: fill to (79,5), then line wrap and row wrap
    for (int i = 0; i < 478; i++) send(8'(8'h61 + i % 26));
    @(negedge clk);
    check_lit("at_79_5", 1, 12'd478, 8'(8'h61 + 477 % 26), 7'd79, 5'd5, 1, 0, 1);
    send(8'h5A); @(negedge clk);
    check_lit("wrap_Z", 1, 12'd479, 8'h5A, 7'd0, 5'd6, 1, 0, 1);
    for (int i = 0; i < 23; i++) send(8'h0A);
    @(negedge clk);
    check_lit("lf_row29", 0, 12'd0, 8'h00, 7'd0, 5'd29, 1, 0, 0);
    send(8'h0A); @(negedge clk);
    check_lit("lf_wrap", 0, 12'd0, 8'h00, 7'd0, 5'd0, 1, 0, 0);

    // 3: backspace across a row boundary and at home
    for (int i = 0; i < 3; i++) send(8'h0A);
    send(8'h08); @(negedge clk);
    check_lit("bs_row", 1, 12'd239, 8'h20, 7'd79, 5'd2, 1, 0, 1);
    send(8'h0D); @(negedge clk);
    check_lit("cr", 0, 12'd0, 8'h00, 7'd0, 5'd2, 1, 0, 0);
    for (int i = 0; i < 28; i++) send(8'h0A);
    send(8'h08); @(negedge clk);
    check_lit("bs_home", 0, 12'd0, 8'h00, 7'd0, 5'd0, 1, 0, 0);
    send(8'h78); send(8'h08); @(negedge clk);
    check_lit("bs_col", 1, 12'd0, 8'h20, 7'd0, 5'd0, 1, 0, 1);

    // 4: full clear
    send(8'h43); send(8'h0C);
    cnt = 0;
    @(negedge clk);
    while (busy === 1'b1 && cnt < 3000) begin
      cnt++;
      @(negedge clk);
    end
    checks++;
    if (cnt == 2400) passes++;
    else $display("FAIL clear_len got %0d busy cycles, want 2400", cnt);
    check_lit("clear_done", 0, 12'd0, 8'h00, 7'd0, 5'd0, 1, 0, 0);

    // 5: reset in the middle of a clear
    send(8'h51); send(8'h0C);
    repeat (100) @(posedge clk);
    #1 rst_n = 1'b0;
    @(negedge clk);
    check_lit("rst_mid_clear", 0, 12'd0, 8'h00, 7'd0, 5'd0, 1, 0, 1);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check_lit("rst_release", 0, 12'd0, 8'h00, 7'd0, 5'd0, 1, 0, 1);

    // 6: ignored bytes are consumed without effect
    send(8'h6B);
    send(8'h07); @(negedge clk);
    check_lit("ign_07", 0, 12'd0, 8'h6B, 7'd1, 5'd0, 1, 0, 0);
    send(8'hFF); @(negedge clk);
    check_lit("ign_FF", 0, 12'd0, 8'h6B, 7'd1, 5'd0, 1, 0, 0);
    send(8'h6D); @(negedge clk);
    check_lit("after_ign", 1, 12'd1, 8'h6D, 7'd2, 5'd0, 1, 0, 1);

    repeat (2) @(negedge clk);
    cmp_en = 1'b0;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout got no finish, want finish");
    $fatal(1, "timeout");
  end

endmodule
